// File: rtl/qpd_sweep_ctrl_if.sv
// Control/status bundle between the QPD sweep controller and its host/capture logic.
// The controller connects through the slave modport, the driving side through master.
interface qpd_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic [7:0]  delay_start;
  logic [7:0]  delay_stop;
  logic [7:0]  delay_step;
  logic [7:0]  repeats;
  logic        capture_done;
  logic        trigger;
  logic [7:0]  cur_delay;
  logic [15:0] point_index;
  logic        busy;
  logic        done;
  logic        timeout_err;

  modport master (
    output start, abort, delay_start, delay_stop, delay_step, repeats, capture_done,
    input  trigger, cur_delay, point_index, busy, done, timeout_err
  );

  modport slave (
    input  start, abort, delay_start, delay_stop, delay_step, repeats, capture_done,
    output trigger, cur_delay, point_index, busy, done, timeout_err
  );
endinterface

// File: rtl/qpd_sweep_ctrl.sv
// Quarter-period delay sweep: steps a trigger delay from start to stop, firing
// `repeats` triggers per point and waiting for a capture acknowledge after each.
//
// state    | meaning
// S_IDLE   | waiting for start; outputs hold last sweep's values
// S_DELAY  | counting up to cur_delay, trigger fires on the matching cycle
// S_WAIT   | waiting for capture_done, bounded by TIMEOUT_CYCLES
// S_NEXT   | repeat the point or advance the delay
// S_FINISH | one-cycle done pulse, then back to idle
module qpd_sweep_ctrl #(
  parameter int TIMEOUT_CYCLES   = 65535,
  parameter int SAMPLE_FREQUENCY = 100000
) (
  input  logic            sclock,
  input  logic            rst,
  qpd_sweep_ctrl_if.slave bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536 || SAMPLE_FREQUENCY < 1) begin : g_param_check
    $error("qpd_sweep_ctrl: TIMEOUT_CYCLES must be 1..65536 and SAMPLE_FREQUENCY positive");
  end

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_WAIT, S_NEXT, S_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  rep_cnt_q, rep_cnt_d;
  logic [7:0]  cur_delay_q, cur_delay_d;
  logic [15:0] point_index_q, point_index_d;
  logic [7:0]  stop_q, stop_d;
  logic [7:0]  step_q, step_d;
  logic [7:0]  repeats_q, repeats_d;
  logic        trig_q, trig_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        tout_q, tout_d;

  logic [8:0]  nxt;
  logic [7:0]  rep_lim;
  logic        rep_last;

  assign nxt      = {1'b0, cur_delay_q} + {1'b0, step_q};
  assign rep_lim  = (repeats_q == 8'd0) ? 8'd1 : repeats_q;
  assign rep_last = ({1'b0, rep_cnt_q} + 9'd1) >= {1'b0, rep_lim};

  // trig_q is computed one cycle ahead so it is high exactly on the cycle whose
  // DELAY count equals cur_delay; in DELAY it doubles as the "count matched" flag.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rep_cnt_d     = rep_cnt_q;
    cur_delay_d   = cur_delay_q;
    point_index_d = point_index_q;
    stop_d        = stop_q;
    step_d        = step_q;
    repeats_d     = repeats_q;
    trig_d        = 1'b0;
    done_d        = 1'b0;
    tout_d        = tout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          stop_d        = bus.delay_stop;
          step_d        = bus.delay_step;
          repeats_d     = bus.repeats;
          cur_delay_d   = bus.delay_start;
          rep_cnt_d     = 8'd0;
          point_index_d = 16'd0;
          tout_d        = 1'b0;
          cnt_d         = 16'd0;
          trig_d        = (bus.delay_start == 8'd0);
          state_d       = S_DELAY;
        end
      end
      S_DELAY: begin
        if (trig_q) begin
          point_index_d = point_index_q + 16'd1;
          cnt_d         = 16'd0;
          state_d       = S_WAIT;
        end else begin
          cnt_d  = cnt_q + 16'd1;
          trig_d = ((cnt_q[7:0] + 8'd1) == cur_delay_q);
        end
      end
      S_WAIT: begin
        if (bus.capture_done) begin
          cnt_d   = 16'd0;
          state_d = S_NEXT;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = 16'd0;
          tout_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_NEXT: begin
        cnt_d = 16'd0;
        if (!rep_last) begin
          rep_cnt_d = rep_cnt_q + 8'd1;
          trig_d    = (cur_delay_q == 8'd0);
          state_d   = S_DELAY;
        end else if (nxt > {1'b0, stop_q} || nxt[8] || step_q == 8'd0) begin
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          cur_delay_d = nxt[7:0];
          rep_cnt_d   = 8'd0;
          state_d     = S_DELAY;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (bus.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = 16'd0;
      trig_d  = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sclock) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 16'd0;
      rep_cnt_q     <= 8'd0;
      cur_delay_q   <= 8'd0;
      point_index_q <= 16'd0;
      stop_q        <= 8'd0;
      step_q        <= 8'd0;
      repeats_q     <= 8'd0;
      trig_q        <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      tout_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rep_cnt_q     <= rep_cnt_d;
      cur_delay_q   <= cur_delay_d;
      point_index_q <= point_index_d;
      stop_q        <= stop_d;
      step_q        <= step_d;
      repeats_q     <= repeats_d;
      trig_q        <= trig_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      tout_q        <= tout_d;
    end
  end

  assign bus.trigger     = trig_q;
  assign bus.cur_delay   = cur_delay_q;
  assign bus.point_index = point_index_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = tout_q;

endmodule

// File: tb/tb_qpd_sweep_ctrl.sv
// Directed bench for qpd_sweep_ctrl: hand-computed sweeps, timing, timeout,
// abort and reset corners, checked with immediate assertions.
module tb_qpd_sweep_ctrl;
  logic sclock = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] trig_delays[$];

  qpd_sweep_ctrl_if bus();

  qpd_sweep_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .sclock (sclock),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sclock = ~sclock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclock);
    #1;
  endtask

  task automatic start_sweep(input logic [7:0] ds, input logic [7:0] dp,
                             input logic [7:0] st, input logic [7:0] rp);
    bus.delay_start = ds;
    bus.delay_stop  = dp;
    bus.delay_step  = st;
    bus.repeats     = rp;
    bus.start       = 1'b1;
    tick();
    bus.start       = 1'b0;
  endtask

  // Returns the number of cycles until trigger is high, leaving time in that cycle.
  task automatic wait_trigger(input int budget, output int off);
    off = -1;
    for (int c = 0; c < budget; c++) begin
      if (bus.trigger) begin
        off = c;
        break;
      end
      tick();
    end
  endtask

  // Acknowledges each trigger `lat` cycles later (lat<=0: never) until done is seen.
  task automatic run_sweep(input int lat, input int budget,
                           output int ntrig, output int ndone, output int ncyc);
    int pend;
    pend  = -1;
    ntrig = 0;
    ndone = 0;
    ncyc  = -1;
    trig_delays.delete();
    for (int c = 0; c < budget; c++) begin
      bus.capture_done = 1'b0;
      if (pend > 0) pend--;
      if (pend == 0) begin
        bus.capture_done = 1'b1;
        pend = -1;
      end
      if (bus.trigger) begin
        ntrig++;
        trig_delays.push_back(bus.cur_delay);
        if (lat > 0) pend = lat;
      end
      if (bus.done) begin
        ndone++;
        ncyc = c;
        break;
      end
      tick();
    end
    bus.capture_done = 1'b0;
  endtask

  function automatic logic [31:0] trig_at(input int i);
    return (i < trig_delays.size()) ? 32'(trig_delays[i]) : 32'hDEAD;
  endfunction

  initial begin
    int off, nt, nd, nc;
    int exp_d[3];

    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.delay_start = 8'd0;
    bus.delay_stop = 8'd0;
    bus.delay_step = 8'd0;
    bus.repeats = 8'd0;
    bus.capture_done = 1'b0;
    tick();
    tick();
    check("rst_trigger", bus.trigger, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_timeout", bus.timeout_err, 0);
    check("rst_cur_delay", bus.cur_delay, 0);
    check("rst_point_index", bus.point_index, 0);
    rst = 1'b0;
    tick();

    // basic sweep 2..6 step 2
    start_sweep(8'd2, 8'd6, 8'd2, 8'd1);
    check("basic_busy", bus.busy, 1);
    run_sweep(3, 200, nt, nd, nc);
    exp_d = '{2, 4, 6};
    check("basic_ntrig", nt, 3);
    check("basic_ndone", nd, 1);
    for (int i = 0; i < 3; i++) check($sformatf("basic_delay%0d", i), trig_at(i), exp_d[i]);
    check("basic_point_index", bus.point_index, 3);
    check("basic_cur_delay", bus.cur_delay, 6);
    check("basic_timeout", bus.timeout_err, 0);
    tick();
    check("basic_done_1cyc", bus.done, 0);
    check("basic_busy_low", bus.busy, 0);

    // trigger timing: delay 5 and delay 0
    start_sweep(8'd5, 8'd5, 8'd1, 8'd1);
    wait_trigger(20, off);
    check("trig_off5", off, 5);
    run_sweep(2, 50, nt, nd, nc);
    check("trig5_ntrig", nt, 1);
    check("trig5_ndone", nd, 1);
    tick();
    start_sweep(8'd0, 8'd0, 8'd1, 8'd1);
    wait_trigger(5, off);
    check("trig_off0", off, 0);
    run_sweep(2, 50, nt, nd, nc);
    check("trig0_ndone", nd, 1);
    check("trig0_cur_delay", bus.cur_delay, 0);
    tick();

    // repeats with delay overflow at the top of the range
    start_sweep(8'd250, 8'd255, 8'd10, 8'd3);
    run_sweep(2, 2000, nt, nd, nc);
    check("ovf_ntrig", nt, 3);
    check("ovf_ndone", nd, 1);
    for (int i = 0; i < 3; i++) check($sformatf("ovf_delay%0d", i), trig_at(i), 250);
    check("ovf_cur_delay", bus.cur_delay, 250);
    check("ovf_point_index", bus.point_index, 3);
    tick();

    // timeout with no capture_done
    start_sweep(8'd1, 8'd1, 8'd1, 8'd1);
    wait_trigger(10, off);
    check("to_trig_off", off, 1);
    run_sweep(0, 40, nt, nd, nc);
    check("to_ndone", nd, 1);
    check("to_done_latency", nc, 9);
    check("to_flag", bus.timeout_err, 1);
    tick();
    check("to_busy_low", bus.busy, 0);
    check("to_flag_sticky", bus.timeout_err, 1);

    // capture_done on the last allowed WAIT cycle wins over the timeout
    start_sweep(8'd1, 8'd1, 8'd1, 8'd1);
    check("to_flag_cleared", bus.timeout_err, 0);
    wait_trigger(10, off);
    run_sweep(8, 40, nt, nd, nc);
    check("tie_ndone", nd, 1);
    check("tie_done_latency", nc, 10);
    check("tie_no_timeout", bus.timeout_err, 0);
    tick();

    // abort during WAIT
    start_sweep(8'd2, 8'd6, 8'd2, 8'd1);
    wait_trigger(10, off);
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_trigger", bus.trigger, 0);
    check("abort_done", bus.done, 0);
    nt = 0;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.trigger) nt++;
      if (bus.done) nd++;
      tick();
    end
    check("abort_no_trig", nt, 0);
    check("abort_no_done", nd, 0);
    check("abort_point_index", bus.point_index, 1);
    check("abort_cur_delay", bus.cur_delay, 2);

    // start while busy ignored; config changes after start have no effect
    start_sweep(8'd3, 8'd3, 8'd1, 8'd1);
    bus.delay_start = 8'd0;
    bus.delay_stop  = 8'd200;
    bus.delay_step  = 8'd1;
    bus.repeats     = 8'd4;
    bus.start       = 1'b1;
    tick();
    bus.start       = 1'b0;
    run_sweep(2, 100, nt, nd, nc);
    check("busy_start_ntrig", nt, 1);
    check("busy_start_delay", trig_at(0), 3);
    check("busy_start_ndone", nd, 1);
    check("busy_start_point_index", bus.point_index, 1);
    tick();

    // step=0 with repeats=0 gives a single point
    start_sweep(8'd4, 8'd10, 8'd0, 8'd0);
    run_sweep(2, 100, nt, nd, nc);
    check("step0_ntrig", nt, 1);
    check("step0_ndone", nd, 1);
    tick();

    // start > stop runs one point at start
    start_sweep(8'd9, 8'd3, 8'd1, 8'd1);
    run_sweep(2, 100, nt, nd, nc);
    check("inv_ntrig", nt, 1);
    check("inv_delay", trig_at(0), 9);
    check("inv_ndone", nd, 1);
    tick();

    // reset mid-DELAY, with start held during reset
    start_sweep(8'd50, 8'd60, 8'd5, 8'd1);
    for (int c = 0; c < 10; c++) tick();
    check("rstmid_busy_before", bus.busy, 1);
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    rst = 1'b0;
    check("rstmid_trigger", bus.trigger, 0);
    check("rstmid_done", bus.done, 0);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_timeout", bus.timeout_err, 0);
    check("rstmid_cur_delay", bus.cur_delay, 0);
    check("rstmid_point_index", bus.point_index, 0);
    nt = 0;
    nd = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus.trigger) nt++;
      if (bus.done) nd++;
      tick();
    end
    check("rstmid_no_trig", nt, 0);
    check("rstmid_no_done", nd, 0);
    check("rstmid_idle", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
